bias_add_array: RTL and testbench



---
 rtl/bias_add_array.sv | 153 +++++++++++++++
 tb/tb_bias_add_array.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_add_array.sv
// bias_add_array: per-channel bias adder placed between the kernel accumulators
// and the activation/requantisation stage. Each of CH channels owns a signed
// bias register. The data path is a two-stage valid/ready pipeline:
//   S1 holds the biased sum at AC_BW+1 bits.
//   S2 holds the result sized to AB_BW bits, saturated when narrower.
// Optional build macro: BIAS_RELU_EN. When defined, negative results are forced
// to zero after saturation. The saturation flags are left untouched.
module bias_add_array #(
  parameter int CH    = 25,
  parameter int AC_BW = 24,
  parameter int B_BW  = 8,
  parameter int AB_BW = 25,
  parameter int BA_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                bias_we,
  input  logic [BA_W-1:0]     bias_waddr,
  input  logic [B_BW-1:0]     bias_wdata,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [CH*AC_BW-1:0] i_acc,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [CH*AB_BW-1:0] o_acc_bias,
  output logic [CH-1:0]       o_sat
);

  // Width of the exact biased sum; adding a B_BW <= AC_BW bias cannot overflow it.
  localparam int S = AC_BW + 1;

  logic [B_BW-1:0]  bias_r   [CH];
  logic             adv_s;
  logic             s1_v_r;
  logic [S-1:0]     s1_sum_r [CH];
  logic [S-1:0]     sum_s    [CH];
  logic [AB_BW-1:0] sized_s  [CH];
  logic [CH-1:0]    sat_s;
  logic [AB_BW-1:0] res_s    [CH];

  // Pipeline advance: enabled, not in reset, and the output slot is empty or being drained.
  always_comb begin
    adv_s = en & (~o_valid | o_ready) & ~rst;
  end

  assign i_ready = adv_s;

  // Bias bank write port; it runs regardless of en and of pipeline state.
  // Addresses >= CH match no channel and are therefore dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CH; k++) begin
        bias_r[k] <= {B_BW{1'b0}};
      end
    end else if (bias_we) begin
      for (int k = 0; k < CH; k++) begin
        if (bias_waddr == BA_W'(k)) begin
          bias_r[k] <= bias_wdata;
        end
      end
    end
  end

  // Stage-1 adder: both operands are sign-extended to S bits.
  // The adder reads the bank as it stands before any same-cycle write lands.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      sum_s[k] = S'($signed(i_acc[k*AC_BW +: AC_BW])) + S'($signed(bias_r[k]));
    end
  end

  // Stage-1 register. Capturing the sum freezes this beat's bias snapshot,
  // so later bias writes cannot alter a beat already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_r <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        s1_sum_r[k] <= {S{1'b0}};
      end
    end else if (adv_s) begin
      s1_v_r <= i_valid;
      for (int k = 0; k < CH; k++) begin
        s1_sum_r[k] <= sum_s[k];
      end
    end
  end

  generate
    if (AB_BW >= S) begin : g_wide
      // Output is at least as wide as the sum: sign-extend, never saturate.
      always_comb begin
        sat_s = {CH{1'b0}};
        for (int k = 0; k < CH; k++) begin
          sized_s[k] = AB_BW'($signed(s1_sum_r[k]));
        end
      end
    end else begin : g_narrow
      // Number of top sum bits that must all equal the sign for the value to fit.
      localparam int HB = S - AB_BW + 1;

      // Clamp each sum to the AB_BW signed range and flag the channels that were clamped.
      always_comb begin
        sat_s = {CH{1'b0}};
        for (int k = 0; k < CH; k++) begin
          sized_s[k] = s1_sum_r[k][AB_BW-1:0];
          if ((s1_sum_r[k][S-1:AB_BW-1] != {HB{1'b0}}) &&
              (s1_sum_r[k][S-1:AB_BW-1] != {HB{1'b1}})) begin
            sat_s[k] = 1'b1;
            if (s1_sum_r[k][S-1]) begin
              sized_s[k] = {1'b1, {(AB_BW-1){1'b0}}};
            end else begin
              sized_s[k] = {1'b0, {(AB_BW-1){1'b1}}};
            end
          end else begin
            sat_s[k] = 1'b0;
          end
        end
      end
    end
  endgenerate

  // Optional rectification applied after saturation; the saturation flags pass through unchanged.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
`ifdef BIAS_RELU_EN
      if (sized_s[k][AB_BW-1]) begin
        res_s[k] = {AB_BW{1'b0}};
      end else begin
        res_s[k] = sized_s[k];
      end
`else
      res_s[k] = sized_s[k];
`endif
    end
  end

  // Stage-2 output register. Every output holds while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_acc_bias <= {(CH*AB_BW){1'b0}};
      o_sat      <= {CH{1'b0}};
    end else if (adv_s) begin
      o_valid <= s1_v_r;
      o_sat   <= sat_s;
      for (int k = 0; k < CH; k++) begin
        o_acc_bias[k*AB_BW +: AB_BW] <= res_s[k];
      end
    end
  end

endmodule

// File: tb/tb_bias_add_array.sv
// Directed, table-driven bench for bias_add_array.
// Two instances share every input:
//   dut   uses the default parameters (AB_BW=25, no saturation possible).
//   dut16 uses AB_BW=16 (saturating).
// Expected values honour BIAS_RELU_EN when it is defined for the build.
module tb_bias_add_array;
  localparam int CH    = 25;
  localparam int AC_BW = 24;
  localparam int B_BW  = 8;
  localparam int AB_BW = 25;
  localparam int BA_W  = 5;
  localparam int AB16  = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic                bias_we;
  logic [BA_W-1:0]     bias_waddr;
  logic [B_BW-1:0]     bias_wdata;
  logic                i_valid;
  logic                i_ready;
  logic                i_ready16;
  logic [CH*AC_BW-1:0] i_acc;
  logic                o_valid;
  logic                o_valid16;
  logic                o_ready;
  logic [CH*AB_BW-1:0] o_acc_bias;
  logic [CH*AB16-1:0]  o_acc16;
  logic [CH-1:0]       o_sat;
  logic [CH-1:0]       o_sat16;

  typedef struct {
    int a0; int a1; int b0; int b1;
    int e0; int e1; int s0; int s1;
    logic [1:0] sat;
  } vec_t;

  vec_t tbl [7];
  int   exp_bias [CH];
  int   n_chk = 0;
  int   n_fail = 0;
  int   sent, recv, held;
  bit   stalled_prev, acc_fire;

  always #5 clk = ~clk;

  bias_add_array dut (
    .clk(clk), .rst(rst), .en(en), .bias_we(bias_we), .bias_waddr(bias_waddr),
    .bias_wdata(bias_wdata), .i_valid(i_valid), .i_ready(i_ready), .i_acc(i_acc),
    .o_valid(o_valid), .o_ready(o_ready), .o_acc_bias(o_acc_bias), .o_sat(o_sat)
  );

  bias_add_array #(.AB_BW(AB16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .bias_we(bias_we), .bias_waddr(bias_waddr),
    .bias_wdata(bias_wdata), .i_valid(i_valid), .i_ready(i_ready16), .i_acc(i_acc),
    .o_valid(o_valid16), .o_ready(o_ready), .o_acc_bias(o_acc16), .o_sat(o_sat16)
  );

  function automatic int relu(int x);
`ifdef BIAS_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int out25(int k);
    logic [AB_BW-1:0] t;
    t = o_acc_bias[k*AB_BW +: AB_BW];
    return int'($signed(t));
  endfunction

  function automatic int out16(int k);
    logic [AB16-1:0] t;
    t = o_acc16[k*AB16 +: AB16];
    return int'($signed(t));
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(int k, int v);
    i_acc[k*AC_BW +: AC_BW] = v[AC_BW-1:0];
  endtask

  task automatic wr_bias(int a, int d);
    bias_we    = 1'b1;
    bias_waddr = a[BA_W-1:0];
    bias_wdata = d[B_BW-1:0];
    tick();
    bias_we = 1'b0;
    if (a < CH) exp_bias[a] = d;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; bias_we = 1'b0; bias_waddr = '0; bias_wdata = '0;
    i_valid = 1'b0; i_acc = '0; o_ready = 1'b1;
    for (int k = 0; k < CH; k++) exp_bias[k] = 0;

    //          a0        a1        b0    b1    e0(25)   e1(25)    s0(16)  s1(16)  sat16
    tbl[0] = '{100,      -100,      5,    -3,   105,     -103,     105,    -103,   2'b00};
    tbl[1] = '{32760,    -32760,    20,   -20,  32780,   -32780,   32767,  -32768, 2'b11};
    tbl[2] = '{32747,    -32748,    20,   -20,  32767,   -32768,   32767,  -32768, 2'b00};
    tbl[3] = '{32748,    -32749,    20,   -20,  32768,   -32769,   32767,  -32768, 2'b11};
    tbl[4] = '{8388607,  -8388608,  127,  -128, 8388734, -8388736, 32767,  -32768, 2'b11};
    tbl[5] = '{-5,       5,         127,  -128, 122,     -123,     122,    -123,   2'b00};
    tbl[6] = '{-40000,   40000,     100,  -100, -39900,  39900,    -32768, 32767,  2'b11};

    // Reset state
    repeat (3) tick();
    chk("rst_iready", i_ready, 0);
    chk("rst_iready16", i_ready16, 0);
    chk("rst_ovalid", o_valid, 0);
    chk("rst_acc_zero", int'(o_acc_bias == '0), 1);
    chk("rst_sat", int'(o_sat), 0);
    rst = 1'b0;
    tick();

    // Basic add: beat driven now, output after the second edge
    wr_bias(0, 5);
    wr_bias(24, -3);
    for (int k = 0; k < CH; k++) set_ch(k, (k == 0) ? 100 : (k == 24) ? -100 : 37 * k - 400);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("basic_lat_valid0", o_valid, 0);
    tick();
    chk("basic_valid", o_valid, 1);
    chk("basic_ch0", out25(0), relu(105));
    chk("basic_ch24", out25(24), relu(-103));
    for (int k = 1; k < 24; k++) chk($sformatf("basic_ch%0d", k), out25(k), relu(37 * k - 400));
    chk("basic_sat", int'(o_sat), 0);

    // Table: add and saturation on channels 0 and 1, both widths
    for (int i = 0; i < 7; i++) begin
      wr_bias(0, tbl[i].b0);
      wr_bias(1, tbl[i].b1);
      i_acc = '0;
      set_ch(0, tbl[i].a0);
      set_ch(1, tbl[i].a1);
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      tick();
      chk($sformatf("tbl%0d_valid", i), o_valid, 1);
      chk($sformatf("tbl%0d_valid16", i), o_valid16, 1);
      chk($sformatf("tbl%0d_ch0", i), out25(0), relu(tbl[i].e0));
      chk($sformatf("tbl%0d_ch1", i), out25(1), relu(tbl[i].e1));
      chk($sformatf("tbl%0d_sat", i), int'(o_sat), 0);
      chk($sformatf("tbl%0d_ch0_16", i), out16(0), relu(tbl[i].s0));
      chk($sformatf("tbl%0d_ch1_16", i), out16(1), relu(tbl[i].s1));
      chk($sformatf("tbl%0d_sat16", i), int'(o_sat16), int'(tbl[i].sat));
    end

    // Bias write colliding with accept of beat A; beat B follows
    tick();
    i_acc = '0;
    set_ch(2, 10);
    i_valid = 1'b1; bias_we = 1'b1; bias_waddr = 5'd2; bias_wdata = 8'd7;
    tick();
    bias_we = 1'b0;
    exp_bias[2] = 7;
    tick();
    i_valid = 1'b0;
    chk("coll_A_valid", o_valid, 1);
    chk("coll_A_ch2", out25(2), 10);
    tick();
    chk("coll_B_valid", o_valid, 1);
    chk("coll_B_ch2", out25(2), 17);

    // Out-of-range write, then read the whole bank through a zero beat
    tick();
    wr_bias(30, 9);
    i_acc = '0;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    for (int k = 0; k < CH; k++) chk($sformatf("bank_ch%0d", k), out25(k), relu(exp_bias[k]));

    // en=0 for 4 cycles while o_valid=1; a bias write during the freeze still lands
    tick();
    i_acc = '0;
    set_ch(0, 11);
    i_valid = 1'b1;
    tick();
    set_ch(0, 22);
    tick();
    en = 1'b0;
    set_ch(0, 33);
    bias_we = 1'b1; bias_waddr = 5'd3; bias_wdata = 8'd4;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("en_iready", i_ready, 0);
      chk("en_valid", o_valid, 1);
      chk("en_hold", out25(0), relu(11 + exp_bias[0]));
      tick();
      bias_we = 1'b0;
      exp_bias[3] = 4;
    end
    en = 1'b1;
    #1;
    chk("en_resume_iready", i_ready, 1);
    tick();
    i_valid = 1'b0;
    chk("en_D", out25(0), relu(22 + exp_bias[0]));
    tick();
    chk("en_E_valid", o_valid, 1);
    chk("en_E_ch0", out25(0), relu(33 + exp_bias[0]));
    chk("en_E_ch3", out25(3), 4);

    // Backpressure: 6 beats in ch0 with bias 0, o_ready low in cycles 3-5
    tick();
    wr_bias(0, 0);
    tick();
    i_acc = '0;
    sent = 0; recv = 0; held = 0; stalled_prev = 1'b0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      i_valid = (sent < 6);
      set_ch(0, sent + 1);
      o_ready = !(c >= 3 && c <= 5);
      #2;
      if (stalled_prev) begin
        chk("bp_hold_valid", o_valid, 1);
        chk("bp_hold_data", out25(0), held);
      end
      if (o_valid && !o_ready) begin
        chk("bp_stall_iready", i_ready, 0);
        held = out25(0);
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (o_valid && o_ready) begin
        chk("bp_order", out25(0), recv + 1);
        recv++;
      end
      acc_fire = i_valid && i_ready;
      tick();
      if (acc_fire) sent++;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    chk("bp_count", recv, 6);
    chk("bp_no_extra", o_valid, 0);

    // Reset with two beats in flight
    tick();
    wr_bias(0, 50);
    i_acc = '0;
    set_ch(0, 1);
    i_valid = 1'b1;
    tick();
    set_ch(0, 2);
    tick();
    rst = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("rstmid_iready", i_ready, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < CH; k++) exp_bias[k] = 0;
    chk("rstmid_valid", o_valid, 0);
    chk("rstmid_acc_zero", int'(o_acc_bias == '0), 1);
    chk("rstmid_sat", int'(o_sat), 0);
    i_acc = '0;
    set_ch(0, 5);
    i_valid = 1'b1;
    #1;
    chk("rstmid_first_accept", i_ready, 1);
    tick();
    i_valid = 1'b0;
    chk("rstmid_dropped", o_valid, 0);
    tick();
    chk("rstmid_new_valid", o_valid, 1);
    chk("rstmid_new_ch0", out25(0), 5);
    chk("rstmid_new_ch24", out25(24), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
